cnn_layer_sequencer: RTL and testbench
======================================

// Module: cnn_layer_sequencer
// PURPOSE
//  Top-level layer scheduler for the CNN inference pipeline (conv1, pool1, conv2, pool2, fc).
//  Each layer engine has a start/done handshake. This block launches the engines strictly in order.
//  It skips layers marked bypass, guards every layer with a watchdog, and reports completion or error to the host.
// PARAMETERS
//  NUM_LAYERS      5        number of layer engines, index 0 runs first
//  TIMEOUT_CYCLES  200000   WAIT cycles allowed per layer before error (>=1)
//  TO_W            $clog2(TIMEOUT_CYCLES+1)  watchdog counter width (derived; not overridden)
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-high
//  run          in   1           host start; sampled only in IDLE/ERROR
//  abort        in   1           host abort; any state
//  bypass       in   NUM_LAYERS  per-layer skip mask; latched when run is accepted
//  busy         out  1           high from the cycle after run acceptance through the done cycle
//  done         out  1           1-cycle pulse when all non-bypassed layers are finished
//  error        out  1           sticky watchdog expiry flag
//  err_layer    out  $clog2(NUM_LAYERS)  layer index that timed out
//  cur_layer    out  $clog2(NUM_LAYERS)  layer currently launched/waited on
//  layer_start  out  NUM_LAYERS  one-hot 1-cycle start pulse to engine i (registered)
//  layer_done   in   NUM_LAYERS  engine i completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, error, layer_start, err_layer, cur_layer and watchdog all 0.
//  FSM states: IDLE, LAUNCH, WAIT, FINISH, ERROR (seq_state_t).
//  - IDLE/ERROR + run at cycle c: clear error, latch bypass.
//      Go to LAUNCH on the first non-bypassed layer; if all layers are bypassed, go to FINISH.
//  - LAUNCH (1 cycle): layer_start[cur_layer]=1, watchdog cleared -> WAIT.
//  - WAIT: layer_done is sampled only here and only for bit cur_layer; other bits are ignored.
//      On done, go to the next non-bypassed layer (LAUNCH), or to FINISH if none remains.
//      Otherwise the watchdog increments each cycle.
//  - Timeout: layer_start high in cycle t with no done in cycles t+1..t+TIMEOUT_CYCLES
//      -> ERROR entered at t+TIMEOUT_CYCLES+1.
//      On entry error=1 and err_layer=cur_layer; busy drops to 0 and no done pulse is issued.
//  - FINISH (1 cycle): done=1, busy=1 -> IDLE.
//  Latency:
//    run in cycle c -> first layer_start in c+1.
//    layer_done in d -> next layer_start in d+1; if it was the last layer, done in d+1 and busy=0 in d+2.
//    All layers bypassed: done in c+1.
//  Boundary conditions:
//    run while busy is ignored.
//    abort has priority over run/done/timeout: next state IDLE, busy=0, no done, no layer_start, error cleared.
//    layer_done for cur_layer in the same cycle the watchdog would expire counts as done, not error.
//    Asynchronous reset mid-operation returns to the reset values; engines are not notified.
//  Next non-bypassed layer search: combinational priority scan upward from cur_layer+1; no wrap-around.
// CONFIGURATION
//  PERF_CNT_EN defined:
//    Adds ports perf_sel (in, $clog2(NUM_LAYERS)) and perf_cycles (out, 32).
//    Each layer has a 32-bit counter of its WAIT cycles, including the done cycle.
//    Counters saturate at 2^32-1, clear on run acceptance, and hold after done/error/abort.
//    perf_cycles = counter[perf_sel], driven combinationally.
//  PERF_CNT_EN undefined: no perf ports, no counters; behaviour otherwise identical.
// STRUCTURE
//  cnn_pkg: seq_state_t enum; CNN_NUM_LAYERS=5; DEFAULT_TIMEOUT=200000.
//  Sub-module seq_watchdog: TO_W counter with clr/en inputs and an expire output
//    (expire = en && count==TIMEOUT_CYCLES-1), parameterised by TIMEOUT_CYCLES.
//  FSM, bypass latch, start one-hot register and perf counters live in cnn_layer_sequencer.
// TESTING
//  Engine model: done pulse D cycles after start.
//  1. bypass=0, D=10, run at c -> starts 0..4 at c+1,c+12,c+23,c+34,c+45.
//     done at c+56 (single pulse), busy=0 at c+57.
//  2. bypass=5'b01010, D=4 -> only layers 0, 2 and 4 start; done once.
//     cur_layer sequence is 0, 2, 4.
//  3. bypass=5'b11111 -> no layer_start; done at c+1; busy high only in c+1.
//  4. TIMEOUT_CYCLES=50, layer 2 never done, start[2] at t -> error=1 and err_layer=2 at t+51.
//     No done; later run clears error and restarts at layer 0.
//  5. abort while WAIT on layer 3 -> busy=0 next cycle, no done, no further starts.
//     run pulsed while busy is ignored; layer_done[4] during WAIT on layer 1 is ignored.
//  6. PERF_CNT_EN, D=10 for all layers -> perf_sel=0..4 reads 10 each after done.
//     A second run clears the counters to 0.

Source files
------------

// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared types and defaults for the CNN layer sequencer.
package cnn_pkg;

  localparam int CNN_NUM_LAYERS  = 5;
  localparam int DEFAULT_TIMEOUT = 200000;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FINISH,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Host and layer-engine handshake bundle for cnn_layer_sequencer.
// slave = sequencer side, master = host/engine side.
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 5
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                  run;
  logic                  abort;
  logic [NUM_LAYERS-1:0] bypass;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [LW-1:0]         err_layer;
  logic [LW-1:0]         cur_layer;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [NUM_LAYERS-1:0] layer_done;

  modport slave (
    input  run, abort, bypass, layer_done,
    output busy, done, error, err_layer, cur_layer, layer_start
  );

  modport master (
    output run, abort, bypass, layer_done,
    input  busy, done, error, err_layer, cur_layer, layer_start
  );

endinterface

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Per-layer watchdog: expire fires on the last allowed WAIT cycle.
module seq_watchdog #(
  parameter  int TIMEOUT_CYCLES = 200000,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && count != TO_W'(TIMEOUT_CYCLES))
      count <= count + TO_W'(1);
  end

  assign expire = en && (count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// In-order launcher for the CNN layer engines with bypass mask and watchdog.
// Optional feature: define PERF_CNT_EN for per-layer WAIT cycle counters.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter  int NUM_LAYERS     = CNN_NUM_LAYERS,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  localparam int LW             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  cnn_layer_sequencer_if.slave  bus
`ifdef PERF_CNT_EN
  ,
  input  logic [LW-1:0]         perf_sel,
  output logic [31:0]           perf_cycles
`endif
);

  seq_state_t            state, state_n;
  logic [LW-1:0]         cur, cur_n;
  logic [NUM_LAYERS-1:0] byp;
  logic                  run_acc;
  logic                  expire;

  logic                  busy_q, done_q, error_q;
  logic [LW-1:0]         err_layer_q;
  logic [NUM_LAYERS-1:0] start_q, start_n;

  // Scan source: on acceptance the incoming mask from layer 0, otherwise the
  // latched mask from cur+1 (kept one bit wider so the top layer cannot wrap).
  logic                  accepting;
  logic [NUM_LAYERS-1:0] scan_mask;
  logic [LW:0]           scan_from;
  logic                  found;
  logic [LW-1:0]         found_idx;

  assign accepting = (state == IDLE) || (state == ERROR);
  assign scan_mask = accepting ? bus.bypass : byp;
  assign scan_from = accepting ? '0 : ({1'b0, cur} + (LW+1)'(1));

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && i >= 32'(scan_from) && !scan_mask[i]) begin
        found     = 1'b1;
        found_idx = LW'(i);
      end
    end
  end

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LAUNCH),
    .en    (state == WAIT),
    .expire(expire)
  );

  always_comb begin
    state_n = state;
    cur_n   = cur;
    run_acc = 1'b0;
    start_n = '0;
    unique case (state)
      IDLE, ERROR: begin
        if (bus.run) begin
          run_acc = 1'b1;
          if (found) begin
            state_n = LAUNCH;
            cur_n   = found_idx;
          end else begin
            state_n = FINISH;
          end
        end
      end
      LAUNCH: state_n = WAIT;
      WAIT: begin
        // done on the expiry cycle still counts as completion
        if (bus.layer_done[cur]) begin
          if (found) begin
            state_n = LAUNCH;
            cur_n   = found_idx;
          end else begin
            state_n = FINISH;
          end
        end else if (expire) begin
          state_n = ERROR;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.abort) begin
      state_n = IDLE;
      cur_n   = cur;
      run_acc = 1'b0;
    end
    if (state_n == LAUNCH)
      start_n[cur_n] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      byp         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
      start_q     <= '0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      start_q <= start_n;
      busy_q  <= (state_n == LAUNCH) || (state_n == WAIT) || (state_n == FINISH);
      done_q  <= (state_n == FINISH);
      if (run_acc)
        byp <= bus.bypass;
      if (bus.abort || run_acc) begin
        error_q <= 1'b0;
      end else if (state == WAIT && state_n == ERROR) begin
        error_q     <= 1'b1;
        err_layer_q <= cur;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.err_layer   = err_layer_q;
  assign bus.cur_layer   = cur;
  assign bus.layer_start = start_q;

`ifdef PERF_CNT_EN
  logic [31:0] perf_cnt [NUM_LAYERS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++)
        perf_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        if (run_acc)
          perf_cnt[i] <= '0;
        else if (state == WAIT && 32'(cur) == i && perf_cnt[i] != '1)
          perf_cnt[i] <= perf_cnt[i] + 32'd1;
      end
    end
  end

  assign perf_cycles = (int'(perf_sel) < NUM_LAYERS) ? perf_cnt[perf_sel] : '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer (TIMEOUT_CYCLES=50); PERF_CNT_EN adds perf checks.
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_layer_sequencer_if #(.NUM_LAYERS(5)) bus ();

`ifdef PERF_CNT_EN
  logic [2:0]  perf_sel;
  logic [31:0] perf_cycles;
`endif

  cnn_layer_sequencer #(
    .NUM_LAYERS    (5),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef PERF_CNT_EN
    ,
    .perf_sel   (perf_sel),
    .perf_cycles(perf_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Engine model: done pulse eng_delay cycles after a start seen on an enabled engine.
  logic [4:0] eng_done = '0;
  logic [4:0] eng_mask = '1;
  logic [4:0] xdone    = '0;
  int         eng_delay = 10;
  int         eng_cnt [5];

  assign bus.layer_done = eng_done | xdone;

  initial begin
    for (int i = 0; i < 5; i++) eng_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        eng_done[i] = 1'b0;
        if (reset) begin
          eng_cnt[i] = 0;
        end else begin
          if (eng_cnt[i] > 0) begin
            eng_cnt[i]--;
            if (eng_cnt[i] == 0) eng_done[i] = 1'b1;
          end
          if (bus.layer_start[i] && eng_mask[i]) eng_cnt[i] = eng_delay;
        end
      end
    end
  end

  typedef struct {
    logic [4:0]      bypass;
    int              delay;
    logic [4:0]      mask;
    int              run_k;
    int              abort_k;
    int              xdone_k;
    logic [4:0]      xbits;
    logic [4:0][7:0] exp_start;
    int              exp_done;
    int              exp_err;
    int              exp_err_layer;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] bypass, input int delay, input logic [4:0] mask,
                              input int run_k, input int abort_k, input int xdone_k,
                              input logic [4:0] xbits,
                              input int s0, input int s1, input int s2, input int s3, input int s4,
                              input int exp_done, input int exp_err, input int exp_err_layer);
    vec_t v;
    v.bypass = bypass; v.delay = delay; v.mask = mask;
    v.run_k = run_k; v.abort_k = abort_k; v.xdone_k = xdone_k; v.xbits = xbits;
    v.exp_start[0] = 8'(s0); v.exp_start[1] = 8'(s1); v.exp_start[2] = 8'(s2);
    v.exp_start[3] = 8'(s3); v.exp_start[4] = 8'(s4);
    v.exp_done = exp_done; v.exp_err = exp_err; v.exp_err_layer = exp_err_layer;
    return v;
  endfunction

  localparam int NV = 10;
  vec_t vecs [NV];

  // Offsets are cycles after the run-accept cycle c; 0 means "never".
  task automatic run_vec(input int idx);
    vec_t v;
    int first_start [5];
    int start_cnt [5];
    int done_cnt, first_done, first_err, err_l, busy_at_err;
    v = vecs[idx];
    for (int i = 0; i < 5; i++) begin first_start[i] = 0; start_cnt[i] = 0; end
    done_cnt = 0; first_done = 0; first_err = 0; err_l = 0; busy_at_err = 0;
    eng_delay = v.delay;
    eng_mask  = v.mask;
    bus.bypass = v.bypass;
    bus.run    = 1'b1;
    @(negedge clk);
    bus.bypass = ~v.bypass;
    for (int k = 1; k <= 120; k++) begin
      bus.run   = (k == v.run_k);
      bus.abort = (k == v.abort_k);
      xdone     = (k == v.xdone_k) ? v.xbits : 5'b0;
      for (int i = 0; i < 5; i++) begin
        if (bus.layer_start[i]) begin
          start_cnt[i]++;
          if (first_start[i] == 0) first_start[i] = k;
          check($sformatf("v%0d cur_layer at start %0d", idx, i), 32'(bus.cur_layer), i);
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
      end
      if (bus.error && first_err == 0) begin
        first_err = k; err_l = int'(bus.err_layer); busy_at_err = int'(bus.busy);
      end
      if (k == 1) begin
        check($sformatf("v%0d error cleared", idx), 32'(bus.error), 0);
        check($sformatf("v%0d busy after run", idx), 32'(bus.busy), 1);
      end
      if (v.exp_done != 0 && k == v.exp_done)
        check($sformatf("v%0d busy in done cycle", idx), 32'(bus.busy), 1);
      if (v.exp_done != 0 && k == v.exp_done + 1)
        check($sformatf("v%0d busy after done", idx), 32'(bus.busy), 0);
      if (v.abort_k != 0 && k == v.abort_k + 1)
        check($sformatf("v%0d busy after abort", idx), 32'(bus.busy), 0);
      @(negedge clk);
    end
    bus.run = 1'b0; bus.abort = 1'b0; xdone = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("v%0d start cycle layer %0d", idx, i), 32'(first_start[i]), 32'(v.exp_start[i]));
      check($sformatf("v%0d start count layer %0d", idx, i), 32'(start_cnt[i]),
            (v.exp_start[i] != 0) ? 32'd1 : 32'd0);
    end
    check($sformatf("v%0d done count", idx), 32'(done_cnt), (v.exp_done != 0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d done cycle", idx), 32'(first_done), 32'(v.exp_done));
    check($sformatf("v%0d error cycle", idx), 32'(first_err), 32'(v.exp_err));
    if (v.exp_err != 0) begin
      check($sformatf("v%0d err_layer", idx), 32'(err_l), 32'(v.exp_err_layer));
      check($sformatf("v%0d busy at error", idx), 32'(busy_at_err), 0);
    end
  endtask

`ifdef PERF_CNT_EN
  task automatic perf_check(input int exp);
    for (int i = 0; i < 5; i++) begin
      perf_sel = 3'(i);
      #1;
      check($sformatf("perf_cycles layer %0d", i), perf_cycles, 32'(exp));
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global time limit: got timeout, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    //             bypass    D   mask      run ab  xd  xbits     s0  s1  s2  s3  s4  done err el
    vecs[0] = mk(5'b00000, 10, 5'b11111, 0,  0,  0, 5'b00000,  1, 12, 23, 34, 45,  56,  0, 0);
    vecs[1] = mk(5'b01010,  4, 5'b11111, 0,  0,  0, 5'b00000,  1,  0,  6,  0, 11,  16,  0, 0);
    vecs[2] = mk(5'b11111,  4, 5'b11111, 0,  0,  0, 5'b00000,  0,  0,  0,  0,  0,   1,  0, 0);
    vecs[3] = mk(5'b10001,  3, 5'b11111, 0,  0,  0, 5'b00000,  0,  1,  5,  9,  0,  13,  0, 0);
    vecs[4] = mk(5'b00000,  1, 5'b11111, 0,  0,  0, 5'b00000,  1,  3,  5,  7,  9,  11,  0, 0);
    vecs[5] = mk(5'b11110, 50, 5'b11111, 0,  0,  0, 5'b00000,  1,  0,  0,  0,  0,  52,  0, 0);
    vecs[6] = mk(5'b11110, 51, 5'b11111, 0,  0,  0, 5'b00000,  1,  0,  0,  0,  0,   0, 52, 0);
    vecs[7] = mk(5'b00000,  4, 5'b11011, 0,  0,  0, 5'b00000,  1,  6, 11,  0,  0,   0, 62, 2);
    vecs[8] = mk(5'b00000, 10, 5'b11111, 5, 40, 15, 5'b10000,  1, 12, 23, 34,  0,   0,  0, 0);
    vecs[9] = mk(5'b00100,  2, 5'b11111, 0,  0,  0, 5'b00000,  1,  4,  0,  7, 10,  13,  0, 0);

    reset = 1'b1;
    bus.run = 1'b0; bus.abort = 1'b0; bus.bypass = '0;
`ifdef PERF_CNT_EN
    perf_sel = '0;
`endif
    @(negedge clk); @(negedge clk);
    check("reset busy",        32'(bus.busy), 0);
    check("reset done",        32'(bus.done), 0);
    check("reset error",       32'(bus.error), 0);
    check("reset layer_start", 32'(bus.layer_start), 0);
    check("reset err_layer",   32'(bus.err_layer), 0);
    check("reset cur_layer",   32'(bus.cur_layer), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      run_vec(v);
`ifdef PERF_CNT_EN
      if (v == 0) perf_check(10);
      if (v == 2) perf_check(0);
`endif
    end

    // asynchronous reset while waiting on layer 1
    eng_delay = 10; eng_mask = '1;
    bus.bypass = '0; bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    repeat (15) @(negedge clk);
    check("pre-reset cur_layer", 32'(bus.cur_layer), 1);
    #2 reset = 1'b1;
    #1;
    check("async reset busy",        32'(bus.busy), 0);
    check("async reset cur_layer",   32'(bus.cur_layer), 0);
    check("async reset layer_start", 32'(bus.layer_start), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post-reset idle busy",  32'(bus.busy), 0);
    check("post-reset idle start", 32'(bus.layer_start), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
